// File: rtl/fpu_op_sequencer.sv
// fpu_op_sequencer: buffers operand pairs in a small FIFO and presents them one at a
// time to a free-running FPU. Each pair is held on the FPU inputs for HOLD_CYCLES
// cycles, then the FPU output is captured and offered downstream with valid/ready.
// Optional feature: define FPU_SEQ_ERRCNT_EN to count nonzero-status results in
// err_count (saturating at 255); otherwise err_count is tied to 0.
module fpu_op_sequencer #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned HOLD_CYCLES = 64
) (
  input  logic        clock_100Khz,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_op_a,
  input  logic [31:0] in_op_b,
  output logic [31:0] fpu_op_a,
  output logic [31:0] fpu_op_b,
  input  logic [31:0] fpu_data,
  input  logic [3:0]  fpu_status,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic [3:0]  res_status,
  output logic        busy,
  output logic [7:0]  err_count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [PTR_W:0]   OCC_FULL  = (PTR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] HOLD    = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] OUTPUT  = 2'd3;

  logic [63:0]      fifo_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   occ_q;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             push, pop;

  assign in_ready = (occ_q != OCC_FULL);
  assign push     = in_valid && in_ready;
  // Pop decision uses pre-edge occupancy, so a pair landing in an empty FIFO waits a cycle.
  assign pop      = (state_q == IDLE) && (occ_q != '0);
  assign busy     = (state_q != IDLE) || (occ_q != '0);

  // FIFO storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge clock_100Khz) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= {in_op_a, in_op_b};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clock_100Khz or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push && !pop)      occ_q <= occ_q + (PTR_W + 1)'(1);
      else if (pop && !push) occ_q <= occ_q - (PTR_W + 1)'(1);
    end
  end

  // Next-state and hold-counter logic.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (pop) begin
          state_d    = HOLD;
          hold_cnt_d = HOLD_LOAD;
        end
      end
      HOLD: begin
        if (hold_cnt_q == '0) state_d = CAPTURE;
        else                  hold_cnt_d = hold_cnt_q - CNT_W'(1);
      end
      CAPTURE: state_d = OUTPUT;
      OUTPUT:  if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register and hold counter.
  always_ff @(posedge clock_100Khz or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  // Operand registers (change only on pop) and the captured result.
  always_ff @(posedge clock_100Khz or negedge reset) begin
    if (!reset) begin
      fpu_op_a   <= '0;
      fpu_op_b   <= '0;
      res_data   <= '0;
      res_status <= '0;
      res_valid  <= 1'b0;
    end else begin
      if (pop) begin
        fpu_op_a <= fifo_mem[rd_ptr_q][63:32];
        fpu_op_b <= fifo_mem[rd_ptr_q][31:0];
      end
      if (state_q == CAPTURE) begin
        res_data   <= fpu_data;
        res_status <= fpu_status;
        res_valid  <= 1'b1;
      end else if (state_q == OUTPUT && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

`ifdef FPU_SEQ_ERRCNT_EN
  logic [7:0] err_count_q;

  // Saturating count of captured results whose status is nonzero.
  always_ff @(posedge clock_100Khz or negedge reset) begin
    if (!reset) begin
      err_count_q <= '0;
    end else if (state_q == CAPTURE && fpu_status != 4'd0 && err_count_q != 8'hFF) begin
      err_count_q <= err_count_q + 8'd1;
    end
  end

  assign err_count = err_count_q;
`else
  assign err_count = 8'd0;
`endif

endmodule
